// File: rtl/fp_div_pkg.sv
// Shared types and sizes for the FP32 mantissa divider.
// Widths: QW quotient bits, MW mantissa bits with hidden bit, EXPW exponent bits.
package fp_div_pkg;
  localparam int QW   = 26;
  localparam int MW   = 24;
  localparam int EXPW = 10;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  typedef logic [MW:0] rem_t;
endpackage

// File: rtl/fp_div_step.sv
// One combinational restoring-division step.
// next_rem is the remainder before the left shift.
module fp_div_step
  import fp_div_pkg::*;
(
  input  rem_t          rem,
  input  logic [MW-1:0] divisor,
  output logic          qbit,
  output rem_t          next_rem
);
  rem_t dv;

  assign dv       = {1'b0, divisor};
  assign qbit     = (rem >= dv);
  assign next_rem = qbit ? (rem - dv) : rem;
endmodule

// File: rtl/fp_div_mantissa_iter.sv
// Iterative restoring mantissa divider, one quotient bit per cycle.
// FP_DIV_RADIX4_EN chains two steps per cycle for half the latency.
module fp_div_mantissa_iter
  import fp_div_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [MW-1:0]   dividend_mantissa_normalized,
  input  logic [MW-1:0]   divisor_mantissa_normalized,
  input  logic [7:0]      current_exponent,
  input  logic            result_sign,
  input  logic [4:0]      dividend_shift,
  input  logic [4:0]      divisor_shift,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [QW-1:0]   quotient,
  output logic            sticky,
  output logic [EXPW-1:0] exp_out,
  output logic            sign_out,
  output logic            div_by_zero,
  output logic            zero_result
);
  localparam int CW = $clog2(QW);
`ifdef FP_DIV_RADIX4_EN
  localparam logic [CW-1:0] CNT_INIT = CW'(QW / 2 - 1);
`else
  localparam logic [CW-1:0] CNT_INIT = CW'(QW - 1);
`endif

  div_state_t    state, state_nx;
  rem_t          rem;
  rem_t          rem_last;
  logic [MW-1:0] dvs;
  logic [CW-1:0] cnt;
  logic [QW-1:0] q_nx;
  logic          accept;
  logic          dvs_zero;
  logic          dvd_zero;
  logic          qb0;
  rem_t          nr0;

  assign in_ready = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept   = in_valid && in_ready;
  assign dvs_zero = (divisor_mantissa_normalized == '0);
  assign dvd_zero = (dividend_mantissa_normalized == '0);

  fp_div_step u_step0 (
    .rem     (rem),
    .divisor (dvs),
    .qbit    (qb0),
    .next_rem(nr0)
  );

`ifdef FP_DIV_RADIX4_EN
  logic qb1;
  rem_t rem1;
  rem_t nr1;

  assign rem1 = rem_t'(nr0 << 1);

  fp_div_step u_step1 (
    .rem     (rem1),
    .divisor (dvs),
    .qbit    (qb1),
    .next_rem(nr1)
  );

  assign q_nx     = {quotient[QW-3:0], qb0, qb1};
  assign rem_last = nr1;
`else
  assign q_nx     = {quotient[QW-2:0], qb0};
  assign rem_last = nr0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid) state_nx = (dvs_zero || dvd_zero) ? DONE : CALC;
      CALC: if (cnt == '0) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem         <= '0;
      dvs         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      sticky      <= 1'b0;
      exp_out     <= '0;
      sign_out    <= 1'b0;
      div_by_zero <= 1'b0;
      zero_result <= 1'b0;
    end else if (accept) begin
      rem         <= {1'b0, dividend_mantissa_normalized};
      dvs         <= divisor_mantissa_normalized;
      cnt         <= CNT_INIT;
      quotient    <= '0;
      sticky      <= 1'b0;
      exp_out     <= {2'b00, current_exponent}
                   - {5'b0, dividend_shift}
                   + {5'b0, divisor_shift};
      sign_out    <= result_sign;
      div_by_zero <= dvs_zero;
      zero_result <= !dvs_zero && dvd_zero;
    end else if (state == CALC) begin
      quotient <= q_nx;
      rem      <= rem_t'(rem_last << 1);
      cnt      <= cnt - 1'b1;
      if (cnt == '0) sticky <= (rem_last != '0);
    end
  end
endmodule

// File: tb/tb_fp_div_mantissa_iter.sv
// Self-checking bench for fp_div_mantissa_iter.
// Reference quotient is plain integer division of the scaled mantissas.
module tb_fp_div_mantissa_iter;
  localparam int QW = 26;
  localparam int MW = 24;
`ifdef FP_DIV_RADIX4_EN
  localparam int LAT = QW / 2 + 1;
`else
  localparam int LAT = QW + 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [MW-1:0] dvd = '0;
  logic [MW-1:0] dvs = '0;
  logic [7:0]    cexp = '0;
  logic          rsign = 1'b0;
  logic [4:0]    dshift = '0;
  logic [4:0]    vshift = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [QW-1:0] quotient;
  logic          sticky;
  logic [9:0]    exp_out;
  logic          sign_out;
  logic          div_by_zero;
  logic          zero_result;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_div_mantissa_iter dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .in_valid                    (in_valid),
    .in_ready                    (in_ready),
    .dividend_mantissa_normalized(dvd),
    .divisor_mantissa_normalized (dvs),
    .current_exponent            (cexp),
    .result_sign                 (rsign),
    .dividend_shift              (dshift),
    .divisor_shift               (vshift),
    .out_valid                   (out_valid),
    .out_ready                   (out_ready),
    .quotient                    (quotient),
    .sticky                      (sticky),
    .exp_out                     (exp_out),
    .sign_out                    (sign_out),
    .div_by_zero                 (div_by_zero),
    .zero_result                 (zero_result)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [QW-1:0] ref_q(input logic [MW-1:0] a,
                                          input logic [MW-1:0] b);
    longint unsigned num;
    num = longint'(a) << (QW - 1);
    if (b == 0) return '0;
    return QW'(num / longint'(b));
  endfunction

  function automatic logic ref_st(input logic [MW-1:0] a,
                                  input logic [MW-1:0] b);
    longint unsigned num;
    num = longint'(a) << (QW - 1);
    if (b == 0) return 1'b0;
    return (num % longint'(b)) != 0;
  endfunction

  function automatic logic [9:0] ref_exp(input logic [7:0] e,
                                         input logic [4:0] ds,
                                         input logic [4:0] vs);
    int t;
    t = int'(e) - int'(ds) + int'(vs);
    return t[9:0];
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_quotient"}, quotient, 0);
    check({tag, "_sticky"}, sticky, 0);
    check({tag, "_exp_out"}, exp_out, 0);
    check({tag, "_sign_out"}, sign_out, 0);
    check({tag, "_dbz"}, div_by_zero, 0);
    check({tag, "_zr"}, zero_result, 0);
  endtask

  task automatic run_op(input string tag, input logic [MW-1:0] a,
                        input logic [MW-1:0] b, input logic [7:0] e,
                        input logic s, input logic [4:0] ds,
                        input logic [4:0] vs, input int hold);
    int lat;
    int exp_lat;
    logic [QW-1:0] qh;
    @(negedge clk);
    dvd = a; dvs = b; cexp = e; rsign = s; dshift = ds; vshift = vs;
    in_valid = 1'b1;
    check({tag, "_rdy"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dvd = MW'($urandom); dvs = MW'($urandom);
    cexp = 8'($urandom); dshift = 5'($urandom); vshift = 5'($urandom);
    rsign = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    exp_lat = (a == 0 || b == 0) ? 1 : LAT;
    check({tag, "_ovalid"}, out_valid, 1);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_q"}, quotient, ref_q(a, b));
    check({tag, "_st"}, sticky, ref_st(a, b));
    check({tag, "_exp"}, exp_out, ref_exp(e, ds, vs));
    check({tag, "_sign"}, sign_out, s);
    check({tag, "_dbz"}, div_by_zero, (b == 0));
    check({tag, "_zr"}, zero_result, (b != 0 && a == 0));
    qh = quotient;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dvd = MW'($urandom) | 24'h800000; dvs = MW'($urandom) | 24'h800000;
      @(posedge clk);
      #1;
      check({tag, "_hold_ov"}, out_valid, 1);
      check({tag, "_hold_ir"}, in_ready, 0);
      check({tag, "_hold_q"}, quotient, qh);
      check({tag, "_hold_e"}, exp_out, ref_exp(e, ds, vs));
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_drain_ov"}, out_valid, 0);
    check({tag, "_drain_ir"}, in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    logic [MW-1:0] ra, rb;
    #1;
    check_reset_vals("rst_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_vals("rst_rel");

    run_op("one_one", 24'h800000, 24'h800000, 8'd127, 1'b0, 5'd0, 5'd0, 0);
    run_op("one_1p5", 24'h800000, 24'hC00000, 8'd127, 1'b1, 5'd0, 5'd0, 0);
    run_op("1p5_one", 24'hC00000, 24'h800000, 8'd10, 1'b0, 5'd3, 5'd1, 0);
    run_op("dbz", 24'h800000, 24'h000000, 8'd100, 1'b1, 5'd0, 5'd0, 0);
    run_op("both0", 24'h000000, 24'h000000, 8'd100, 1'b0, 5'd0, 5'd0, 0);
    run_op("zero", 24'h000000, 24'hA00000, 8'd50, 1'b1, 5'd0, 5'd2, 0);
    run_op("neg_exp", 24'hFFFFFF, 24'h800001, 8'd2, 1'b0, 5'd31, 5'd0, 0);
    run_op("bp", 24'h900000, 24'hF00000, 8'd77, 1'b1, 5'd4, 5'd6, 5);

    @(negedge clk);
    dvd = 24'hC00000; dvs = 24'hA00000; cexp = 8'd127;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_calc");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (LAT + 5) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("rst_calc_noout", seen, 0);
    check("rst_calc_ir", in_ready, 1);
    run_op("post_rst", 24'h800000, 24'h800000, 8'd127, 1'b0, 5'd0, 5'd0, 0);

    for (int i = 0; i < 20; i++) begin
      ra = MW'($urandom) | 24'h800000;
      rb = MW'($urandom) | 24'h800000;
      run_op($sformatf("rnd%0d", i), ra, rb, 8'($urandom), 1'($urandom),
             5'($urandom), 5'($urandom), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_div_mantissa_iter.md
Name: fp_div_mantissa_iter

Overview:
Iterative restoring mantissa divider. It is the stage directly downstream of the FP32 divide normalizer.
- Consumes the normalizer outputs: normalized 24-bit mantissas, their leading-zero shift amounts, the prepared exponent and the result sign.
- Produces a raw quotient with sticky bit, plus the shift-corrected exponent, for the rounding/pack stage.
- Takes one quotient bit per cycle, with valid/ready handshakes on both sides.

Parameters:
- QW, 26: quotient bits produced. Bit QW-1 has weight 2^0; the rest are fractional bits. Must be even when FP_DIV_RADIX4_EN is defined.
- MW, 24: mantissa width including the hidden bit.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand bundle valid
- in_ready  out  1  block can accept an operand bundle
- dividend_mantissa_normalized  in  MW  normalized dividend mantissa
- divisor_mantissa_normalized  in  MW  normalized divisor mantissa
- current_exponent  in  8  prepared biased exponent
- result_sign  in  1  sign of the result
- dividend_shift  in  5  normalization shift applied to the dividend
- divisor_shift  in  5  normalization shift applied to the divisor
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- quotient  out  QW  raw quotient; value lies in (0.5, 2)
- sticky  out  1  final remainder is nonzero
- exp_out  out  10  signed corrected exponent
- sign_out  out  1  registered result_sign
- div_by_zero  out  1  divisor mantissa was zero
- zero_result  out  1  dividend mantissa was zero

Behaviour:
- Reset is asynchronous and active-low: clk, rst_n. One clock domain.
- Reset values: state=IDLE, in_ready=1, out_valid=0, and quotient, sticky, exp_out, sign_out, div_by_zero, zero_result all 0.
- FSM has three states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - An operand bundle is accepted when in_valid&&in_ready. On acceptance, all inputs are latched.
  - exp_out = {2'b00,current_exponent} - dividend_shift + divisor_shift, computed in 10-bit two's complement.
  - Remainder register (MW+1 bits) is loaded with the dividend; quotient is cleared; step counter is loaded with QW-1.
  - Next state:
    - Divisor mantissa == 0: go to DONE with div_by_zero=1, quotient=0, sticky=0.
    - Otherwise, dividend mantissa == 0: go to DONE with zero_result=1, quotient=0, sticky=0.
    - Otherwise: go to CALC.
- CALC (in_ready=0), each cycle:
  - If rem >= divisor: q bit = 1 and rem -= divisor; else q bit = 0.
  - Shift q in at the quotient LSB; rem <<= 1.
  - The counter decrements. When the step with counter==0 executes, the state moves to DONE.
  - On that same edge, sticky = (the post-step remainder, before its shift, != 0).
- DONE:
  - out_valid=1. All outputs are held stable while out_ready=0.
  - On out_valid&&out_ready: out_valid=0, go to IDLE.
  - in_ready rises the next cycle; there is no accept-while-draining.
- Latency: QW+1 cycles from accept to out_valid, i.e. 27 with QW=26. The fast paths (div_by_zero, zero_result) take 1 cycle.
- Width rule: rem < 2*divisor at all times, so MW+1 bits never overflow.
- When both operands are zero, div_by_zero takes priority.
- in_valid is ignored outside IDLE. Operand inputs may change freely after acceptance.
- rst_n asserted mid-CALC or mid-DONE: immediate return to reset values; the in-flight result is discarded with no output.

Optional Feature:
FP_DIV_RADIX4_EN:
- Defined: two restoring steps are chained combinationally per cycle. The counter starts at QW/2-1 and latency becomes QW/2+1 cycles (14). Results are bit-identical.
- Undefined: one step per cycle as described above.

Decomposition:
- Package fp_div_pkg holds:
  - localparams QW, MW, EXPW=10;
  - typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
  - typedef logic [MW:0] rem_t.
- Sub-module fp_div_step: one combinational restoring step.
  - Inputs: rem, divisor. Outputs: qbit, next_rem (pre-shift).
  - Instantiated once, or twice in series under FP_DIV_RADIX4_EN.

Test Plan:
- 1.0/1.0: mantissas 0x800000/0x800000, shifts 0, exp 127 -> quotient=0x2000000, sticky=0, exp_out=127, out_valid at cycle 27 after accept (14 with FP_DIV_RADIX4_EN).
- 1.0/1.5: 0x800000/0xC00000 -> quotient=0x1555555, sticky=1.
- 1.5/1.0 with dividend_shift=3, divisor_shift=1, exp=10 -> quotient=0x3000000, sticky=0, exp_out=8.
- Divisor mantissa 0x000000, dividend 0x800000 -> div_by_zero=1, quotient=0, out_valid 1 cycle after accept. Both mantissas 0 -> div_by_zero=1, zero_result=0.
- Backpressure: out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored. Release -> in_ready=1 the next cycle.
- rst_n pulsed low at CALC step 10 -> out_valid stays 0 and in_ready=1 after release. A following 1.0/1.0 run yields the correct result.
